// File: rtl/lag_pkg.sv
// Shared types and helpers for the multi-channel latency timer.
package lag_pkg;

    // Default width of the cycle counter and of each per-channel result.
    localparam int CNT_W_DEF = 24;

    // Measurement FSM states.
    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } state_e;

    // Cycles from a raw sensor edge to the debounced level that the capture logic sees.
    function automatic int calc_lat(input int sync_stages, input int debounce);
        return sync_stages + debounce - 1;
    endfunction

endpackage

// File: rtl/lag_timer_if.sv
// Stimulus, sensor and result signals of the latency timer.
interface lag_timer_if
    import lag_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int CNT_W    = CNT_W_DEF
);
    logic                      start;
    logic [CHANNELS-1:0]       sensor_pol;
    logic [CHANNELS-1:0]       sensor_in;
    logic                      busy;
    logic                      done;
    logic [CHANNELS*CNT_W-1:0] result;
    logic [CHANNELS-1:0]       hit;
    logic [CHANNELS-1:0]       early;
    logic                      overlap;

    // Pattern logic side: issues the stimulus pulse and reads results.
    modport master (
        output start, sensor_pol, sensor_in,
        input  busy, done, result, hit, early, overlap
    );

    // Timer side.
    modport slave (
        input  start, sensor_pol, sensor_in,
        output busy, done, result, hit, early, overlap
    );
endinterface

// File: rtl/lag_chan.sv
// One sensor channel: synchroniser, polarity normalisation and debouncer.
// active_o already reflects the sample that completes a debounce run, so a
// raw edge just before clock edge k is visible to the capture logic at edge
// k + SYNC_STAGES + DEBOUNCE - 1.
module lag_chan
    import lag_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sensor_i,
    input  logic pol_i,
    output logic active_o
);
    localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   deb_q;
    logic [DB_W-1:0]        run_q;
    logic                   sample;
    logic                   differs;
    logic                   settle;

    // Normalise to active-high and decide whether this sample completes a run.
    always_comb begin
        sample   = sync_q[SYNC_STAGES-1] ~^ pol_i;
        differs  = (sample != deb_q);
        settle   = differs && (run_q == DB_LAST);
        active_o = settle ? sample : deb_q;
    end

    // Synchroniser chain; cleared to the inactive raw level.
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{~pol_i}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sensor_i};
        end
    end

    // Debouncer: count consecutive samples that disagree with the accepted level.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            deb_q <= 1'b0;
            run_q <= '0;
        end else if (!differs) begin
            run_q <= '0;
        end else if (settle) begin
            deb_q <= sample;
            run_q <= '0;
        end else begin
            run_q <= run_q + DB_W'(1);
        end
    end

endmodule

// File: rtl/lag_timer.sv
// Multi-channel latency timer: counts from a stimulus pulse until each
// sensor channel's first debounced assertion, or until the timeout.
module lag_timer
    import lag_pkg::*;
#(
    parameter int               CHANNELS    = 2,
    parameter int               CNT_W       = CNT_W_DEF,
    parameter int               SYNC_STAGES = 2,
    parameter int               DEBOUNCE    = 4,
    parameter logic [CNT_W-1:0] TIMEOUT     = CNT_W'(4000000)
) (
    input  logic       clk,
    input  logic       reset_n,
    lag_timer_if.slave bus
);
    localparam int LAT = calc_lat(SYNC_STAGES, DEBOUNCE);

    state_e                           state_q, state_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [CHANNELS-1:0][CNT_W-1:0]   result_q, result_d;
    logic [CHANNELS-1:0]              captured_q, captured_d;
    logic [CHANNELS-1:0]              hit_q, hit_d;
    logic [CHANNELS-1:0]              early_q, early_d;
    logic                             busy_q, busy_d;
    logic                             done_q, done_d;
    logic                             overlap_q, overlap_d;
    logic [CHANNELS-1:0]              active;
    logic [CNT_W:0]                   cnt_inc;
    logic [CNT_W-1:0]                 lat_result;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        lag_chan #(
            .SYNC_STAGES(SYNC_STAGES),
            .DEBOUNCE   (DEBOUNCE)
        ) u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .sensor_i(bus.sensor_in[g]),
            .pol_i   (bus.sensor_pol[g]),
            .active_o(active[g])
        );
    end

    // Latency of a capture at this edge: the edge count minus the input pipeline, floored at 0.
    always_comb begin
        cnt_inc    = {1'b0, cnt_q} + (CNT_W + 1)'(1);
        lat_result = '0;
        if (cnt_inc >= (CNT_W + 1)'(LAT)) begin
            lat_result = CNT_W'(cnt_inc - (CNT_W + 1)'(LAT));
        end
    end

    // Next-state and capture logic.
    // NOTE: every target gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        captured_d = captured_q;
        hit_d      = hit_q;
        early_d    = early_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        overlap_d  = overlap_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cnt_d      = '0;
                    result_d   = '0;
                    overlap_d  = 1'b0;
                    early_d    = active;
                    hit_d      = active;
                    captured_d = active;
                    busy_d     = 1'b1;
                    state_d    = COUNT;
                end
            end
            COUNT: begin
                if (bus.start) begin
                    overlap_d = 1'b1;
                end
                for (int i = 0; i < CHANNELS; i++) begin
                    if (!captured_q[i] && active[i]) begin
                        captured_d[i] = 1'b1;
                        hit_d[i]      = 1'b1;
                        result_d[i]   = lat_result;
                    end else if (!captured_q[i] && (cnt_q == TIMEOUT)) begin
                        result_d[i] = TIMEOUT;
                    end
                end
                if ((&captured_q) || (cnt_q == TIMEOUT)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.start) begin
                    overlap_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers.
    // NOTE: the result bank is a set of visible output registers, so it is reset like any other state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            result_q   <= '0;
            captured_q <= '0;
            hit_q      <= '0;
            early_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overlap_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            captured_q <= captured_d;
            hit_q      <= hit_d;
            early_q    <= early_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overlap_q  <= overlap_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign bus.hit     = hit_q;
    assign bus.early   = early_q;
    assign bus.overlap = overlap_q;

endmodule

// File: tb/tb_lag_timer.sv
// Directed bench for lag_timer: capture timing, glitch rejection, timeout,
// early/polarity handling, overlap and mid-measurement reset.
module tb_lag_timer;
    localparam int CH    = 2;
    localparam int CW    = 24;
    localparam int NEVER = 1 << 30;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    lag_timer_if #(.CHANNELS(CH), .CNT_W(CW)) bus ();

    lag_timer #(
        .CHANNELS   (CH),
        .CNT_W      (CW),
        .SYNC_STAGES(2),
        .DEBOUNCE   (4),
        .TIMEOUT    (24'd1000)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Start at edge 0, then drive sensors so each is stable before edge k.
    // Returns the edge index at which done was first seen (-1 if never).
    task automatic measure(input int r0, input int r1, input int g0, input int glen,
                           input int restart_at, input int rst_at, input int budget,
                           output int done_edge, output logic ov_at1, output logic busy_at1);
        int j;
        j = 0;
        done_edge = -1;
        ov_at1 = 1'b0;
        busy_at1 = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        while (j < budget) begin
            bus.sensor_in[0] = (j + 1 >= r0) || ((j + 1 >= g0) && (j + 1 < g0 + glen));
            bus.sensor_in[1] = (j + 1 >= r1);
            bus.start = (j + 1 == restart_at);
            reset_n = (j + 1 != rst_at);
            @(posedge clk);
            j++;
            #1;
            if (j == 1) begin
                ov_at1 = bus.overlap;
                busy_at1 = bus.busy;
            end
            if (bus.done) begin
                done_edge = j;
                break;
            end
            if (j == rst_at) break;
            @(negedge clk);
        end
        bus.start = 1'b0;
        reset_n = 1'b1;
    endtask

    task automatic settle_idle(input logic [CH-1:0] pol);
        @(negedge clk);
        bus.sensor_pol = pol;
        bus.sensor_in = '0;
        repeat (15) @(posedge clk);
    endtask

    task automatic check_done_drops(input string tag);
        @(posedge clk);
        #1;
        check(tag, bus.done, 1'b0);
    endtask

    initial begin
        int de;
        int seen;
        logic ov1;
        logic b1;

        bus.start = 1'b0;
        bus.sensor_pol = 2'b11;
        bus.sensor_in = 2'b00;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_result", bus.result, 0);
        check("rst_hit", bus.hit, 0);
        check("rst_early", bus.early, 0);
        check("rst_overlap", bus.overlap, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(posedge clk);

        // Basic capture
        measure(100, 250, NEVER, 0, NEVER, NEVER, 2000, de, ov1, b1);
        check("basic_busy_at1", b1, 1);
        check("basic_done_edge", de, 256);
        check("basic_busy_at_done", bus.busy, 0);
        check("basic_res0", bus.result[CW-1:0], 100);
        check("basic_res1", bus.result[2*CW-1:CW], 250);
        check("basic_hit", bus.hit, 2'b11);
        check("basic_early", bus.early, 2'b00);
        check("basic_overlap", bus.overlap, 0);
        check_done_drops("basic_done_1cyc");
        settle_idle(2'b11);

        // Glitch rejection
        measure(120, 200, 50, 3, NEVER, NEVER, 2000, de, ov1, b1);
        check("glitch_done_edge", de, 206);
        check("glitch_res0", bus.result[CW-1:0], 120);
        check("glitch_res1", bus.result[2*CW-1:CW], 200);
        check("glitch_hit", bus.hit, 2'b11);
        settle_idle(2'b11);

        // Timeout
        measure(10, NEVER, NEVER, 0, NEVER, NEVER, 1100, de, ov1, b1);
        check("tmo_done_edge", de, 1001);
        check("tmo_res0", bus.result[CW-1:0], 10);
        check("tmo_res1", bus.result[2*CW-1:CW], 1000);
        check("tmo_hit", bus.hit, 2'b01);
        check_done_drops("tmo_done_1cyc");
        settle_idle(2'b11);

        // Early and polarity: channel 0 active-low and already low
        settle_idle(2'b10);
        measure(NEVER, 40, NEVER, 0, NEVER, NEVER, 2000, de, ov1, b1);
        check("early_done_edge", de, 46);
        check("early_early", bus.early, 2'b01);
        check("early_hit", bus.hit, 2'b11);
        check("early_res0", bus.result[CW-1:0], 0);
        check("early_res1", bus.result[2*CW-1:CW], 40);
        settle_idle(2'b11);

        // Overlap: second start during COUNT leaves timing alone
        measure(100, 150, NEVER, 0, 30, NEVER, 2000, de, ov1, b1);
        check("ovl_done_edge", de, 156);
        check("ovl_overlap", bus.overlap, 1);
        check("ovl_res0", bus.result[CW-1:0], 100);
        check("ovl_res1", bus.result[2*CW-1:CW], 150);
        settle_idle(2'b11);

        // Reset mid-measurement
        measure(NEVER, NEVER, NEVER, 0, 30, 60, 2000, de, ov1, b1);
        check("rstm_ovl_cleared_by_start", ov1, 0);
        check("rstm_no_done_before", de, -1);
        check("rstm_busy", bus.busy, 0);
        check("rstm_done", bus.done, 0);
        check("rstm_result", bus.result, 0);
        check("rstm_hit", bus.hit, 0);
        check("rstm_early", bus.early, 0);
        check("rstm_overlap", bus.overlap, 0);
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.done) seen++;
        end
        check("rstm_no_done_after", seen, 0);

        // Fresh measurement after reset
        measure(20, 35, NEVER, 0, NEVER, NEVER, 2000, de, ov1, b1);
        check("fresh_done_edge", de, 41);
        check("fresh_res0", bus.result[CW-1:0], 20);
        check("fresh_res1", bus.result[2*CW-1:CW], 35);
        check("fresh_hit", bus.hit, 2'b11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
